// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: addresses, instruction words, fetch FSM states.
package cpu_pkg;

  typedef logic [7:0]  pc_t;
  typedef logic [15:0] instr_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  localparam pc_t RESET_PC_DEFAULT = 8'h00;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory read port plus decode-side valid/ready head port.
interface fetch_queue_if;
  import cpu_pkg::*;

  logic   imem_en;
  pc_t    imem_addr;
  instr_t imem_rdata;
  logic   out_valid;
  logic   out_ready;
  instr_t out_instr;
  pc_t    out_pc;
  pc_t    out_pc_plus1;

  modport master (
    output imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_plus1,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_en, imem_addr, out_valid, out_instr, out_pc, out_pc_plus1,
    output imem_rdata, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction queue: registered storage, read/write pointers, count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_push, do_pop;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  always_comb begin
    do_push  = push && ((count_q != CW'(DEPTH)) || pop);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside the occupied window, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues sequential imem reads and queues results for decode.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter pc_t         RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          redirect,
  input  pc_t           redirect_pc,
  fetch_queue_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  pc_t           pc_q, pc_d;
  logic          inflight_q, inflight_d;
  pc_t           inflight_pc_q, inflight_pc_d;
  fetch_entry_t  hold_q, hold_d;

  logic [CW-1:0] count;
  logic [CW:0]   occ;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          issue, push, pop, valid;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (redirect),
    .count     (count),
    .head      (head)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state follows en alone; redirect never changes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: issue a read while running, not redirecting, and room is reserved.
  always_comb begin
    occ           = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    issue         = (state_q == RUN) && !redirect && (occ < (CW+1)'(DEPTH));
    bus.imem_en   = issue;
    bus.imem_addr = pc_q;
  end

  // Datapath next state: pc advance/redirect, in-flight tracking, head hold register.
  always_comb begin
    valid         = (count != '0);
    pop           = valid && bus.out_ready;
    push          = inflight_q && !redirect;
    push_data.pc    = inflight_pc_q;
    push_data.instr = bus.imem_rdata;
    pc_d          = pc_q;
    if (redirect)   pc_d = redirect_pc;
    else if (issue) pc_d = pc_q + 8'd1;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    hold_d        = valid ? head : hold_q;
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      hold_q.pc     <= RESET_PC;
      hold_q.instr  <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      hold_q        <= hold_d;
    end
  end

  // Head comes from queue flops when occupied, otherwise from the hold flops.
  always_comb begin
    bus.out_valid    = valid;
    bus.out_instr    = valid ? head.instr : hold_q.instr;
    bus.out_pc       = valid ? head.pc    : hold_q.pc;
    bus.out_pc_plus1 = bus.out_pc + 8'd1;
  end

endmodule
